// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI register slave.
// The frame is an 8-bit command (write flag + 7-bit address) followed by the data phase.
package spi_pkg;

   localparam int CMD_W      = 8;
   localparam int ADDR_W     = 7;
   localparam int CMD_WR_BIT = 7;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      DATA    = 3'd2,
      DONE    = 3'd3,
      WAIT_CS = 3'd4
   } spi_state_t;

endpackage

// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle between the Pmod header (master side) and the register slave.
interface spi_reg_slave_if;

   logic sclk;
   logic cs;
   logic mosi;
   logic miso;

   modport master (
      output sclk,
      output cs,
      output mosi,
      input  miso
   );

   modport slave (
      input  sclk,
      input  cs,
      input  mosi,
      output miso
   );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with rise/fall detection on the
// synchronised value. RST_VAL is the idle level the chain is forced to in reset.
module sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
         r_prev <= RST_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_rise = r_sync & ~r_prev;
   assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_reg_slave.sv
// Mode-0 SPI slave with an addressable register bank: command byte, then DATA_W
// data bits; writes land in the bank, reads shift the addressed register out on MISO.
module spi_reg_slave
   import spi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int N_REGS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   spi_reg_slave_if.slave             spi,
   output logic [N_REGS*DATA_W-1:0]   regs,
   output logic                       wr_valid,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [DATA_W-1:0]          wr_data
);

   logic              w_sclk_sync_unused;
   logic              w_sclk_rise;
   logic              w_sclk_fall;
   logic              w_cs_sync;
   logic              w_cs_rise;
   logic              w_cs_fall;
   logic              w_mosi_sync;
   logic              w_mosi_rise_unused;
   logic              w_mosi_fall_unused;

   spi_state_t        r_state;
   logic [5:0]        r_bit_cnt;
   logic [1:0]        r_settle;
   logic [CMD_W-2:0]  r_cmd;
   logic              r_op_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_rx;
   logic [DATA_W-1:0] r_tx;
   logic              r_wr_pend;
   logic              r_miso;
   logic              r_wr_valid;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic [DATA_W-1:0] r_regs [N_REGS];

   logic [CMD_W-1:0]  w_cmd_next;
   logic [DATA_W-1:0] w_rx_next;
   logic [DATA_W-1:0] w_tx_shift;
   logic [DATA_W-1:0] w_rd_data;
   logic              w_mapped;
   logic              w_first_fall;

   sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
      .clk    (clk),
      .rst    (rst),
      .i_async(spi.sclk),
      .o_sync (w_sclk_sync_unused),
      .o_rise (w_sclk_rise),
      .o_fall (w_sclk_fall)
   );

   sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
      .clk    (clk),
      .rst    (rst),
      .i_async(spi.cs),
      .o_sync (w_cs_sync),
      .o_rise (w_cs_rise),
      .o_fall (w_cs_fall)
   );

   sync_edge #(.RST_VAL(1'b0)) u_mosi_sync (
      .clk    (clk),
      .rst    (rst),
      .i_async(spi.mosi),
      .o_sync (w_mosi_sync),
      .o_rise (w_mosi_rise_unused),
      .o_fall (w_mosi_fall_unused)
   );

   assign w_cmd_next   = {r_cmd, w_mosi_sync};
   assign w_rx_next    = (r_rx << 1) | DATA_W'(w_mosi_sync);
   assign w_tx_shift   = r_tx << 1;
   assign w_mapped     = (int'(r_addr) < N_REGS);
   assign w_first_fall = (r_bit_cnt == 6'd0);

   // Unmapped addresses match no entry and therefore read back as zero.
   always_comb begin
      w_rd_data = '0;
      for (int k = 0; k < N_REGS; k++) begin
         if (int'(r_addr) == k) w_rd_data = r_regs[k];
      end
   end

   // Reset leaves the FSM in WAIT_CS; it only reaches IDLE once the cs chain has
   // flushed its forced-high reset value and shows cs really high, so a frame
   // already in flight at reset release is never picked up halfway.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= WAIT_CS;
         r_bit_cnt <= 6'd0;
         r_settle  <= 2'd0;
         r_op_wr   <= 1'b0;
         r_addr    <= '0;
         r_wr_pend <= 1'b0;
      end else begin
         r_wr_pend <= 1'b0;
         if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
         case (r_state)
            IDLE: begin
               if (w_cs_fall) begin
                  r_state   <= CMD;
                  r_bit_cnt <= 6'd0;
               end
            end
            CMD: begin
               if (w_cs_rise) begin
                  r_state <= IDLE;
               end else if (w_sclk_rise) begin
                  if (r_bit_cnt == 6'(CMD_W - 1)) begin
                     r_state   <= DATA;
                     r_bit_cnt <= 6'd0;
                     r_op_wr   <= w_cmd_next[CMD_WR_BIT];
                     r_addr    <= w_cmd_next[ADDR_W-1:0];
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 6'd1;
                  end
               end
            end
            DATA: begin
               if (w_cs_rise) begin
                  r_state <= IDLE;
               end else if (w_sclk_rise) begin
                  if (r_bit_cnt == 6'(DATA_W - 1)) begin
                     r_state   <= DONE;
                     r_wr_pend <= r_op_wr & w_mapped;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 6'd1;
                  end
               end
            end
            DONE: begin
               if (w_cs_rise) r_state <= IDLE;
            end
            WAIT_CS: begin
               if ((r_settle == 2'd3) && w_cs_sync) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((r_state == CMD) && w_sclk_rise) r_cmd <= w_cmd_next[CMD_W-2:0];
      if ((r_state == DATA) && w_sclk_rise) r_rx <= w_rx_next;
      if ((r_state == DATA) && w_sclk_fall) r_tx <= w_first_fall ? w_rd_data : w_tx_shift;
   end

   // First falling edge of the data phase loads the addressed register; later ones shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_miso <= 1'b0;
      end else if ((r_state == DATA) && w_sclk_fall) begin
         r_miso <= ~r_op_wr & (w_first_fall ? w_rd_data[DATA_W-1] : w_tx_shift[DATA_W-1]);
      end else if (r_state != DATA) begin
         r_miso <= 1'b0;
      end
   end

   assign spi.miso = r_miso & ~w_cs_sync & (r_state == DATA);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_REGS; k++) r_regs[k] <= '0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else begin
         r_wr_valid <= r_wr_pend;
         if (r_wr_pend) begin
            r_wr_addr <= r_addr;
            r_wr_data <= r_rx;
            for (int k = 0; k < N_REGS; k++) begin
               if (int'(r_addr) == k) r_regs[k] <= r_rx;
            end
         end
      end
   end

   for (genvar k = 0; k < N_REGS; k++) begin : g_flat
      assign regs[k*DATA_W +: DATA_W] = r_regs[k];
   end

   assign wr_valid = r_wr_valid;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;

endmodule
